sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-in parallel-out receiver that sits directly downstream of the `piso` shift register. It consumes the `piso` serial bit stream, qualified by a bit-valid strobe and a frame-start marker, and reassembles WIDTH-bit words. Each finished word is presented on a registered parallel output with a valid/ready handshake. Framing errors and dropped words are reported through sticky flags.

## Interface
- `WIDTH`, 4: bits per word; must be ≥ 2.
- `MSB_FIRST`, 1: 1 places the first received bit at `dout[WIDTH-1]`; 0 places it at `dout[0]`.
- `CONTINUOUS`, 0: 1 stays in SHIFT after a word completes; 0 returns to IDLE.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `sin` in 1: serial data bit, sampled only when `sin_valid`=1.
- `sin_valid` in 1: qualifies `sin` this cycle.
- `frame_start` in 1: marks the start of a word; a `sin` accepted in the same cycle is bit 0 of that word.
- `dout` out WIDTH: assembled word.
- `dout_valid` out 1: `dout` holds an unconsumed word.
- `dout_ready` in 1: consumer accepts `dout` when `dout_valid`=1 and `dout_ready`=1.
- `busy` out 1: high while in SHIFT.
- `overrun` out 1: sticky; a completed word was dropped.
- `frame_err` out 1: sticky; `frame_start` arrived mid-word.
- `clr_err` in 1: synchronous clear of `overrun` and `frame_err`.

## Operation
- States:
  - **IDLE:** `sin_valid` is ignored until `frame_start`=1, which moves the block to SHIFT.
  - **SHIFT:** the block assembles bits.
- Bit counter runs 0..WIDTH-1.
  - On `frame_start`, the counter is set to 0. If `sin_valid`=1 in the same cycle, that bit is stored and the counter becomes 1.
  - In SHIFT, each `sin_valid` stores `sin` into the shift register and increments the counter.
- Bit placement: MSB_FIRST=1 shifts left, entering at the LSB, so the first bit ends up at `dout[WIDTH-1]`. MSB_FIRST=0 shifts right, entering at the MSB.
- A word completes when the WIDTH-th bit is accepted. On completion:
  - The counter returns to 0.
  - The next state is SHIFT if CONTINUOUS=1, otherwise IDLE.
  - The word transfers to `dout` if the output register is free, i.e. `dout_valid`=0, or `dout_valid`=1 with `dout_ready`=1 in the same cycle. `dout_valid` is then 1.
  - If the output register is not free, the word is discarded, `overrun` is set, and `dout` is unchanged.
- Handshake: `dout` is stable while `dout_valid`=1 and `dout_ready`=0. An accept with no new word clears `dout_valid` on the next edge.
- `frame_start` in SHIFT with counter ≠ 0:
  - The partial word is discarded and `frame_err` is set.
  - Counter restarts as above, including capture of a same-cycle bit.
- `frame_start` in SHIFT with counter = 0 is legal and sets no error.
- If `frame_start` and a completing bit arrive in the same cycle, `frame_start` wins: the partial word is discarded, `frame_err` is set, and there is no output transfer.
- `clr_err`: if an error event occurs in the same cycle, the flag remains set (set wins).

## Timing
- Reset values, applied asynchronously: state IDLE, counter 0, shift register 0, `dout`=0, `dout_valid`=0, `busy`=0, `overrun`=0, `frame_err`=0.
- Latency: the edge that samples the final bit also loads `dout` and raises `dout_valid`. Both are visible in the following cycle. No combinational path from `sin` to `dout`.
- `dout_ready` → `dout_valid` deassert: one edge.
- `busy` is registered and equals (state==SHIFT).
- Reset asserted mid-word or mid-handshake discards everything. No word is emitted after reset release.
- Back-to-back operation: with CONTINUOUS=1 and `sin_valid` held high, one word completes every WIDTH cycles with no gap cycles.

## Structure
- Shared package `sipo_rx_pkg`:
  - state encoding localparams `ST_IDLE`=1'b0, `ST_SHIFT`=1'b1;
  - counter-width helper (clog2 of WIDTH).
- Single module; no sub-module. Shift register, counter, FSM and output register are all inline.
- Top-level pairing: `piso.out` connects to `sin`. The `piso` load/shift control drives `frame_start` and `sin_valid`.

## Test plan
- Basic, WIDTH=4, MSB_FIRST=1: `frame_start`+`sin_valid` with bits 1,0,0,1 on 4 consecutive cycles, `dout_ready`=1 → `dout`=4'b1001 and `dout_valid` high for one cycle, one cycle after the 4th bit; `busy` drops then.
- LSB-first: MSB_FIRST=0, same bits 1,0,0,1 → `dout`=4'b1001. Then bits 1,1,0,0 → `dout`=4'b0011.
- Backpressure/overrun: CONTINUOUS=1, `dout_ready`=0, words 4'b1010 then 4'b0110 → `dout` stays 4'b1010 and `overrun`=1. `clr_err` pulse → `overrun`=0. `dout_ready`=1 → `dout_valid`=0 next cycle.
- Framing error: 2 bits sent, then `frame_start` with new word 4'b1100 → `frame_err`=1 and `dout`=4'b1100. There is no output for the partial word.
- Reset mid-word: `rst` driven low after 3 bits, then released → all outputs 0, state IDLE. A later full word 4'b0101 is received correctly.
- Simultaneous events: `clr_err` in the same cycle as a new overrun → `overrun` remains 1. Completing bit coincident with `frame_start` → no output, `frame_err`=1.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared types and helpers for the sipo_rx receiver.
//   state_t  - receiver FSM state (IDLE waits for frame_start, SHIFT assembles bits)
//   cnt_w()  - width of a bit counter spanning 0..w-1 (at least 1 bit)
package sipo_rx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in parallel-out receiver for the piso bit stream.
// Reassembles WIDTH-bit words from sin (qualified by sin_valid, framed by
// frame_start) and presents them on a registered valid/ready output.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous reset, active low
//   sin          - serial data bit
//   sin_valid    - sin is valid this cycle
//   frame_start  - first bit of a word (a same-cycle sin is bit 0)
//   dout         - assembled word
//   dout_valid   - dout holds an unconsumed word
//   dout_ready   - consumer accepts dout
//   busy         - receiver is in SHIFT
//   overrun      - sticky: a completed word was dropped
//   frame_err    - sticky: frame_start arrived mid-word
//   clr_err      - synchronous clear of overrun/frame_err
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int unsigned     CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word;
    logic             take;
    logic             done;
    logic             out_free;
    logic             err_frame;
    logic             err_ovr;

    // MSB-first shifts left (enters at LSB); LSB-first shifts right (enters at MSB)
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST)
            return {cur[WIDTH-2:0], b};
        else
            return {b, cur[WIDTH-1:1]};
    endfunction

    always_comb begin
        // frame_start overrides any same-cycle bit of the old word
        take      = (state == ST_SHIFT) && sin_valid && !frame_start;
        done      = take && (cnt == LAST);
        out_free  = !dout_valid || dout_ready;
        err_frame = frame_start && (state == ST_SHIFT) && (cnt != '0);
        err_ovr   = done && !out_free;
        word      = shift_in(sreg, sin);
        state_nxt = state;
        if (frame_start)
            state_nxt = ST_SHIFT;
        else if (done)
            state_nxt = CONTINUOUS ? ST_SHIFT : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            sreg       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_SHIFT);

            if (frame_start) begin
                sreg <= sin_valid ? shift_in('0, sin) : '0;
                cnt  <= sin_valid ? CW'(1) : '0;
            end else if (take) begin
                sreg <= word;
                cnt  <= done ? '0 : cnt + CW'(1);
            end

            if (done && out_free) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            // error set takes priority over a same-cycle clear
            if (err_ovr)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;

            if (err_frame)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;

    logic clk = 1'b0;
    logic rst;
    logic sin, sin_valid, frame_start, dout_ready, clr_err;

    logic [3:0] m_dout, l_dout, c_dout;
    logic       m_dv, m_busy, m_ovr, m_ferr;
    logic       l_dv, l_busy, l_ovr, l_ferr;
    logic       c_dv, c_busy, c_ovr, c_ferr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1), .CONTINUOUS(1'b0)) u_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
        .dout(m_dout), .dout_valid(m_dv), .dout_ready(dout_ready), .busy(m_busy),
        .overrun(m_ovr), .frame_err(m_ferr), .clr_err(clr_err));

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
        .dout(l_dout), .dout_valid(l_dv), .dout_ready(dout_ready), .busy(l_busy),
        .overrun(l_ovr), .frame_err(l_ferr), .clr_err(clr_err));

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1)) u_cont (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
        .dout(c_dout), .dout_valid(c_dv), .dout_ready(dout_ready), .busy(c_busy),
        .overrun(c_ovr), .frame_err(c_ferr), .clr_err(clr_err));

    typedef struct {
        logic       fs, sv, b, rdy, clr;
        logic [3:0] dout;
        logic       dv, busy, ferr;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic fs, sv, b, rdy, clr,
                                input logic [3:0] d, input logic dv, bz, fe);
        vec_t v;
        v.fs = fs; v.sv = sv; v.b = b; v.rdy = rdy; v.clr = clr;
        v.dout = d; v.dv = dv; v.busy = bz; v.ferr = fe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fs, input logic sv, input logic b);
        frame_start = fs;
        sin_valid   = sv;
        sin         = b;
        tick();
    endtask

    task automatic do_reset();
        frame_start = 1'b0; sin_valid = 1'b0; sin = 1'b0; clr_err = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(1,1,1,1,0, 4'b0000, 0,1,0);
        tbl[1]  = mk(0,1,0,1,0, 4'b0000, 0,1,0);
        tbl[2]  = mk(0,1,0,1,0, 4'b0000, 0,1,0);
        tbl[3]  = mk(0,1,1,1,0, 4'b1001, 1,0,0);
        tbl[4]  = mk(0,0,0,1,0, 4'b1001, 0,0,0);
        tbl[5]  = mk(0,1,1,1,0, 4'b1001, 0,0,0);
        tbl[6]  = mk(1,1,1,1,0, 4'b1001, 0,1,0);
        tbl[7]  = mk(0,1,0,1,0, 4'b1001, 0,1,0);
        tbl[8]  = mk(1,1,1,1,0, 4'b1001, 0,1,1);
        tbl[9]  = mk(0,1,1,1,0, 4'b1001, 0,1,1);
        tbl[10] = mk(0,0,0,1,0, 4'b1001, 0,1,1);
        tbl[11] = mk(0,1,0,1,0, 4'b1001, 0,1,1);
        tbl[12] = mk(0,1,0,1,0, 4'b1100, 1,0,1);
        tbl[13] = mk(0,0,0,1,1, 4'b1100, 0,0,0);
        tbl[14] = mk(1,0,0,1,0, 4'b1100, 0,1,0);
        tbl[15] = mk(1,1,0,1,0, 4'b1100, 0,1,0);
        tbl[16] = mk(0,1,1,1,0, 4'b1100, 0,1,0);
        tbl[17] = mk(0,1,1,1,0, 4'b1100, 0,1,0);
        tbl[18] = mk(0,1,0,1,0, 4'b0110, 1,0,0);
        tbl[19] = mk(0,0,0,0,0, 4'b0110, 1,0,0);
        tbl[20] = mk(0,0,0,1,0, 4'b0110, 0,0,0);

        dout_ready = 1'b0;
        do_reset();
        chk("rst_dout", 32'(m_dout), 32'h0);
        chk("rst_dv",   32'(m_dv),   32'h0);
        chk("rst_busy", 32'(m_busy), 32'h0);
        chk("rst_ovr",  32'(m_ovr),  32'h0);
        chk("rst_ferr", 32'(m_ferr), 32'h0);

        // main table on the MSB-first, single-word instance
        for (int i = 0; i < 21; i++) begin
            dout_ready = tbl[i].rdy;
            clr_err    = tbl[i].clr;
            drive(tbl[i].fs, tbl[i].sv, tbl[i].b);
            chk($sformatf("tbl%0d_dout", i), 32'(m_dout), 32'(tbl[i].dout));
            chk($sformatf("tbl%0d_dv",   i), 32'(m_dv),   32'(tbl[i].dv));
            chk($sformatf("tbl%0d_busy", i), 32'(m_busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_ferr", i), 32'(m_ferr), 32'(tbl[i].ferr));
            chk($sformatf("tbl%0d_ovr",  i), 32'(m_ovr),  32'h0);
        end
        clr_err = 1'b0;

        // LSB-first
        do_reset();
        dout_ready = 1'b1;
        drive(1,1,1); drive(0,1,0); drive(0,1,0); drive(0,1,1);
        chk("lsb_w1_dout", 32'(l_dout), 32'h9);
        chk("lsb_w1_dv",   32'(l_dv),   32'h1);
        chk("lsb_w1_busy", 32'(l_busy), 32'h0);
        drive(1,1,1); drive(0,1,1); drive(0,1,0); drive(0,1,0);
        chk("lsb_w2_dout", 32'(l_dout), 32'h3);
        chk("lsb_w2_dv",   32'(l_dv),   32'h1);
        chk("msb_w2_dout", 32'(m_dout), 32'hC);

        // backpressure / overrun on the continuous instance
        do_reset();
        dout_ready = 1'b0;
        drive(1,1,1); drive(0,1,0); drive(0,1,1); drive(0,1,0);
        chk("ovr_w1_dout", 32'(c_dout), 32'hA);
        chk("ovr_w1_dv",   32'(c_dv),   32'h1);
        chk("ovr_w1_busy", 32'(c_busy), 32'h1);
        chk("ovr_w1_ovr",  32'(c_ovr),  32'h0);
        drive(0,1,0); drive(0,1,1); drive(0,1,1);
        clr_err = 1'b1;
        drive(0,1,0);
        chk("ovr_setwins", 32'(c_ovr),  32'h1);
        chk("ovr_dout",    32'(c_dout), 32'hA);
        chk("ovr_dv",      32'(c_dv),   32'h1);
        drive(0,0,0);
        chk("ovr_clr", 32'(c_ovr), 32'h0);
        clr_err = 1'b0;
        dout_ready = 1'b1;
        drive(0,0,0);
        chk("ovr_accept_dv", 32'(c_dv), 32'h0);

        // completing bit coincident with frame_start
        do_reset();
        dout_ready = 1'b1;
        drive(1,1,1); drive(0,1,0); drive(0,1,0); drive(1,1,1);
        chk("coll_dv",   32'(m_dv),   32'h0);
        chk("coll_ferr", 32'(m_ferr), 32'h1);
        chk("coll_busy", 32'(m_busy), 32'h1);

        // asynchronous reset mid-word
        drive(0,1,0); drive(0,1,1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_dout", 32'(m_dout), 32'h0);
        chk("arst_dv",   32'(m_dv),   32'h0);
        chk("arst_busy", 32'(m_busy), 32'h0);
        chk("arst_ferr", 32'(m_ferr), 32'h0);
        chk("arst_ovr",  32'(m_ovr),  32'h0);
        frame_start = 1'b0; sin_valid = 1'b0;
        tick();
        rst = 1'b1;
        drive(0,1,1);
        drive(0,0,0);
        chk("post_rst_dv",   32'(m_dv),   32'h0);
        chk("post_rst_busy", 32'(m_busy), 32'h0);
        drive(1,1,0); drive(0,1,1); drive(0,1,0); drive(0,1,1);
        chk("post_rst_dout", 32'(m_dout), 32'h5);
        chk("post_rst_wdv",  32'(m_dv),   32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
